// File: rtl/branch_stats_pkg.sv
// Shared constants, counter-pair type and saturating increment for the branch statistics block.
package branch_stats_pkg;

  localparam int unsigned DEF_NUM_CHANNELS = 5;
  localparam int unsigned DEF_CNT_WIDTH    = 16;
  localparam int unsigned DEF_WINDOW       = 256;

  typedef struct packed {
    logic [DEF_CNT_WIDTH-1:0] total;
    logic [DEF_CNT_WIDTH-1:0] correct;
  } stat_pair_t;

  // Callers narrow the result back to their own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/stat_pair_counter.sv
// Saturating total/correct counter pair; the pair freezes together once total is all-ones,
// which keeps correct <= total.
module stat_pair_counter
  import branch_stats_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter type         pair_t    = stat_pair_t
) (
  input  logic  Clk,
  input  logic  reset,
  input  logic  inc,
  input  logic  hit,
  input  logic  clear,
  output pair_t pair,
  output logic  sat_flag
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  pair_t pair_q, pair_d;
  logic  frozen;

  assign frozen = (pair_q.total == CntMax);

  always_comb begin
    pair_d = pair_q;
    if (clear) begin
      pair_d = '0;
    end else if (inc && !frozen) begin
      pair_d.total   = CNT_WIDTH'(sat_inc(32'(pair_q.total), 32'(CntMax)));
      pair_d.correct = pair_q.correct + CNT_WIDTH'(hit);
    end
  end

  // High only on the edge that takes the pair into saturation.
  assign sat_flag = !frozen && (pair_d.total == CntMax);
  assign pair     = pair_q;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      pair_q <= '0;
    end else begin
      pair_q <= pair_d;
    end
  end

endmodule

// File: rtl/branch_stats_multi.sv
// Aggregate and per-provider prediction statistics with window accuracy and a registered read
// port. Optional miss-streak tracking is enabled by defining BRANCH_STATS_STREAK_EN.
module branch_stats_multi
  import branch_stats_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int unsigned WINDOW       = DEF_WINDOW,
  parameter int unsigned CH_W         = $clog2(NUM_CHANNELS),
  parameter int unsigned WIN_W        = $clog2(WINDOW + 1)
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 BranchResult,
  input  logic [CH_W-1:0]      Provider,
  input  logic                 ClearReq,
  input  logic [CH_W-1:0]      RdChan,
  output logic [CNT_WIDTH-1:0] RdCorrect,
  output logic [CNT_WIDTH-1:0] RdTotal,
  output logic [CNT_WIDTH-1:0] CorrectlyPredicted,
  output logic [CNT_WIDTH-1:0] TotalBranches,
  output logic [WIN_W-1:0]     WindowCorrect,
  output logic                 WindowValid,
  output logic                 Saturated
`ifdef BRANCH_STATS_STREAK_EN
  ,
  output logic [CNT_WIDTH-1:0] MaxMissStreak
`endif
);

  typedef struct packed {
    logic [CNT_WIDTH-1:0] total;
    logic [CNT_WIDTH-1:0] correct;
  } pair_t;

  localparam logic [WIN_W-1:0] LastPos = WIN_W'(WINDOW - 1);

  pair_t                 agg_pair;
  pair_t                 ch_pair [NUM_CHANNELS];
  pair_t                 rd_sel;
  logic [NUM_CHANNELS:0] sat_flags;
  logic [WIN_W-1:0]      win_pos_q, win_acc_q;

  stat_pair_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .pair_t    (pair_t)
  ) u_agg (
    .Clk      (Clk),
    .reset    (reset),
    .inc      (enable),
    .hit      (BranchResult),
    .clear    (ClearReq),
    .pair     (agg_pair),
    .sat_flag (sat_flags[NUM_CHANNELS])
  );

  // Out-of-range providers match no channel, so only the aggregate counts them.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : gen_ch
    stat_pair_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .pair_t    (pair_t)
    ) u_ch (
      .Clk      (Clk),
      .reset    (reset),
      .inc      (enable && (Provider == CH_W'(g))),
      .hit      (BranchResult),
      .clear    (ClearReq),
      .pair     (ch_pair[g]),
      .sat_flag (sat_flags[g])
    );
  end

  assign CorrectlyPredicted = agg_pair.correct;
  assign TotalBranches      = agg_pair.total;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (RdChan == CH_W'(i)) rd_sel = ch_pair[i];
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      RdCorrect <= '0;
      RdTotal   <= '0;
    end else if (ClearReq) begin
      RdCorrect <= '0;
      RdTotal   <= '0;
    end else begin
      RdCorrect <= rd_sel.correct;
      RdTotal   <= rd_sel.total;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      Saturated <= 1'b0;
    end else if (ClearReq) begin
      Saturated <= 1'b0;
    end else if (|sat_flags) begin
      Saturated <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      win_pos_q     <= '0;
      win_acc_q     <= '0;
      WindowCorrect <= '0;
      WindowValid   <= 1'b0;
    end else begin
      WindowValid <= 1'b0;
      if (ClearReq) begin
        win_pos_q     <= '0;
        win_acc_q     <= '0;
        WindowCorrect <= '0;
      end else if (enable) begin
        if (win_pos_q == LastPos) begin
          WindowCorrect <= win_acc_q + WIN_W'(BranchResult);
          WindowValid   <= 1'b1;
          win_pos_q     <= '0;
          win_acc_q     <= '0;
        end else begin
          win_pos_q <= win_pos_q + 1'b1;
          win_acc_q <= win_acc_q + WIN_W'(BranchResult);
        end
      end
    end
  end

`ifdef BRANCH_STATS_STREAK_EN
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [CNT_WIDTH-1:0] streak_q, streak_d, max_streak_q;

  always_comb begin
    streak_d = BranchResult ? '0 : CNT_WIDTH'(sat_inc(32'(streak_q), 32'(CntMax)));
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      streak_q     <= '0;
      max_streak_q <= '0;
    end else if (ClearReq) begin
      streak_q     <= '0;
      max_streak_q <= '0;
    end else if (enable) begin
      streak_q <= streak_d;
      if (streak_d > max_streak_q) max_streak_q <= streak_d;
    end
  end

  assign MaxMissStreak = max_streak_q;
`endif

endmodule

// File: tb/tb_branch_stats_multi.sv
// Directed bench for branch_stats_multi: a 16-bit instance and a 4-bit instance share stimulus.
module tb_branch_stats_multi;

  logic        clk = 1'b0;
  logic        reset_n, enable, branch_result, clear_req;
  logic [2:0]  provider, rd_chan;

  logic [15:0] a_rd_correct, a_rd_total, a_correct, a_total;
  logic [3:0]  a_win_correct;
  logic        a_win_valid, a_sat;
  logic [3:0]  s_rd_correct, s_rd_total, s_correct, s_total;
  logic [3:0]  s_win_correct;
  logic        s_win_valid, s_sat;
`ifdef BRANCH_STATS_STREAK_EN
  logic [15:0] a_max_streak;
  logic [3:0]  s_max_streak;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bit win_pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  bit streak_pat [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  branch_stats_multi #(
    .NUM_CHANNELS (5),
    .CNT_WIDTH    (16),
    .WINDOW       (8)
  ) dut (
    .Clk                (clk),
    .reset              (reset_n),
    .enable             (enable),
    .BranchResult       (branch_result),
    .Provider           (provider),
    .ClearReq           (clear_req),
    .RdChan             (rd_chan),
    .RdCorrect          (a_rd_correct),
    .RdTotal            (a_rd_total),
    .CorrectlyPredicted (a_correct),
    .TotalBranches      (a_total),
    .WindowCorrect      (a_win_correct),
    .WindowValid        (a_win_valid),
    .Saturated          (a_sat)
`ifdef BRANCH_STATS_STREAK_EN
    ,
    .MaxMissStreak      (a_max_streak)
`endif
  );

  branch_stats_multi #(
    .NUM_CHANNELS (5),
    .CNT_WIDTH    (4),
    .WINDOW       (8)
  ) dut_s (
    .Clk                (clk),
    .reset              (reset_n),
    .enable             (enable),
    .BranchResult       (branch_result),
    .Provider           (provider),
    .ClearReq           (clear_req),
    .RdChan             (rd_chan),
    .RdCorrect          (s_rd_correct),
    .RdTotal            (s_rd_total),
    .CorrectlyPredicted (s_correct),
    .TotalBranches      (s_total),
    .WindowCorrect      (s_win_correct),
    .WindowValid        (s_win_valid),
    .Saturated          (s_sat)
`ifdef BRANCH_STATS_STREAK_EN
    ,
    .MaxMissStreak      (s_max_streak)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    enable        = 1'b0;
    branch_result = 1'b0;
    clear_req     = 1'b0;
    provider      = 3'd0;
    rd_chan       = 3'd0;
    #2;
    chk("reset_total", 32'(a_total), 0);
    chk("reset_correct", 32'(a_correct), 0);
    chk("reset_rd_total", 32'(a_rd_total), 0);
    chk("reset_win_valid", 32'(a_win_valid), 0);
    chk("reset_sat", 32'(s_sat), 0);
    #10 reset_n = 1'b1;

    // 50 branches on channel 0, first 37 correct
    for (int i = 0; i < 50; i++) begin
      enable        = 1'b1;
      provider      = 3'd0;
      branch_result = (i < 37);
      cyc();
    end
    enable  = 1'b0;
    rd_chan = 3'd0;
    cyc();
    chk("mid_total", 32'(a_total), 50);
    chk("mid_correct", 32'(a_correct), 37);
    chk("mid_rd_total", 32'(a_rd_total), 50);
    chk("mid_rd_correct", 32'(a_rd_correct), 37);
    chk("mid_small_total", 32'(s_total), 15);
    chk("mid_small_sat", 32'(s_sat), 1);

    // Asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1;
    chk("async_total", 32'(a_total), 0);
    chk("async_correct", 32'(a_correct), 0);
    chk("async_rd_total", 32'(a_rd_total), 0);
    chk("async_rd_correct", 32'(a_rd_correct), 0);
    chk("async_small_total", 32'(s_total), 0);
    chk("async_small_sat", 32'(s_sat), 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_reset_total", 32'(a_total), 0);
    chk("post_reset_rd_total", 32'(a_rd_total), 0);

    // Routing: 10 branches on channel 2, first 7 correct
    for (int i = 0; i < 10; i++) begin
      enable        = 1'b1;
      provider      = 3'd2;
      branch_result = (i < 7);
      cyc();
    end
    enable  = 1'b0;
    rd_chan = 3'd2;
    cyc();
    chk("ch2_rd_correct", 32'(a_rd_correct), 7);
    chk("ch2_rd_total", 32'(a_rd_total), 10);
    chk("route_agg_correct", 32'(a_correct), 7);
    chk("route_agg_total", 32'(a_total), 10);
    chk("route_win_correct", 32'(a_win_correct), 7);
    rd_chan = 3'd1;
    cyc();
    chk("ch1_rd_correct", 32'(a_rd_correct), 0);
    chk("ch1_rd_total", 32'(a_rd_total), 0);

    // Out-of-range provider: aggregate only
    enable        = 1'b1;
    provider      = 3'd6;
    branch_result = 1'b1;
    cyc();
    enable  = 1'b0;
    rd_chan = 3'd6;
    cyc();
    chk("oor_agg_total", 32'(a_total), 11);
    chk("oor_agg_correct", 32'(a_correct), 8);
    chk("oor_rd_total", 32'(a_rd_total), 0);
    rd_chan = 3'd2;
    cyc();
    chk("oor_ch2_total", 32'(a_rd_total), 10);

    // Clear colliding with an enabled correct branch
    clear_req     = 1'b1;
    enable        = 1'b1;
    branch_result = 1'b1;
    provider      = 3'd2;
    cyc();
    clear_req = 1'b0;
    enable    = 1'b0;
    chk("clr_total", 32'(a_total), 0);
    chk("clr_correct", 32'(a_correct), 0);
    chk("clr_rd_total", 32'(a_rd_total), 0);
    chk("clr_win_correct", 32'(a_win_correct), 0);
    cyc();
    chk("clr_ch2_total", 32'(a_rd_total), 0);

    // Window of 8: 1,1,0,1,0,1,1,1 -> 6
    provider = 3'd1;
    for (int i = 0; i < 8; i++) begin
      enable        = 1'b1;
      branch_result = win_pat[i];
      cyc();
      if (i == 6) chk("win_valid_early", 32'(a_win_valid), 0);
    end
    enable = 1'b0;
    chk("win_valid", 32'(a_win_valid), 1);
    chk("win_correct", 32'(a_win_correct), 6);
    cyc();
    chk("win_valid_drop", 32'(a_win_valid), 0);
    chk("win_correct_hold", 32'(a_win_correct), 6);
    for (int i = 0; i < 8; i++) begin
      enable        = 1'b1;
      branch_result = 1'b0;
      cyc();
    end
    enable = 1'b0;
    chk("win2_valid", 32'(a_win_valid), 1);
    chk("win2_correct", 32'(a_win_correct), 0);

`ifdef BRANCH_STATS_STREAK_EN
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      enable        = 1'b1;
      branch_result = streak_pat[i];
      cyc();
    end
    enable = 1'b0;
    chk("max_streak", 32'(a_max_streak), 3);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    chk("max_streak_clr", 32'(a_max_streak), 0);
`endif

    // Saturation on the 4-bit instance
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    chk("sat_clr", 32'(s_sat), 0);
    for (int i = 0; i < 20; i++) begin
      enable        = 1'b1;
      provider      = 3'd0;
      branch_result = 1'b1;
      cyc();
      if (i == 13) chk("sat_before", 32'(s_sat), 0);
      if (i == 14) begin
        chk("sat_edge", 32'(s_sat), 1);
        chk("sat_edge_total", 32'(s_total), 15);
      end
    end
    enable  = 1'b0;
    rd_chan = 3'd0;
    cyc();
    chk("sat_total", 32'(s_total), 15);
    chk("sat_correct", 32'(s_correct), 15);
    chk("sat_rd_total", 32'(s_rd_total), 15);
    chk("sat_rd_correct", 32'(s_rd_correct), 15);
    chk("sat_sticky", 32'(s_sat), 1);
    chk("wide_not_sat", 32'(a_sat), 0);
    chk("wide_total", 32'(a_total), 20);
    enable        = 1'b1;
    provider      = 3'd1;
    branch_result = 1'b0;
    cyc();
    enable  = 1'b0;
    rd_chan = 3'd1;
    cyc();
    chk("sat_ch1_total", 32'(s_rd_total), 1);
    chk("sat_ch1_correct", 32'(s_rd_correct), 0);
    chk("sat_agg_frozen", 32'(s_total), 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
